// File: rtl/gpio_rd_master.sv
// gpio_rd_master: drives GPIO read commands for RAM dumps / BER snapshots and streams the readback words
module gpio_rd_master #(
  parameter int WAIT_CYC = 4,
  parameter int NB_ADDR  = 16
) (
  input  logic               clockdsp,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [NB_ADDR-1:0] i_base_adrs,
  input  logic [NB_ADDR:0]   i_num_words,
  output logic [31:0]        o_cmd,
  input  logic [31:0]        i_rdata,
  output logic [31:0]        o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_ADDR-1:0] o_index,
  output logic               o_busy,
  output logic               o_done
);
  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_ARM = 3'd2, S_FRZ = 3'd3,
                         S_WAIT = 3'd4, S_PRES = 3'd5, S_REL = 3'd6, S_DONE = 3'd7;
  localparam logic [31:0] C_REL_RAM = 32'h0480_0000, C_ARM = 32'h0580_0001,
                          C_FRZ = 32'h0580_0000, C_REL_BER = 32'h0680_0000;
  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic               mode;
  logic [NB_ADDR-1:0] base;
  logic [NB_ADDR:0]   num, idx, nxt;
  logic               held, last;
  assign nxt  = idx + 1'b1;
  assign held = cnt == CW'(WAIT_CYC);
  assign last = mode ? idx == (NB_ADDR+1)'(7) : idx == num - 1'b1;
  function automatic logic [31:0] rd_cmd(input logic m, input logic [NB_ADDR:0] i,
                                         input logic [NB_ADDR-1:0] b);
    rd_cmd = m ? 32'h0680_0008 | 32'(i[2:0])
               : 32'h0481_0000 | 32'(NB_ADDR'(b + i[NB_ADDR-1:0]));
  endfunction
  always_ff @(posedge clockdsp) begin
    if (i_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mode    <= 1'b0;
      base    <= '0;
      num     <= '0;
      idx     <= '0;
      o_cmd   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_index <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          mode   <= i_mode;
          base   <= i_base_adrs;
          num    <= i_num_words;
          idx    <= '0;
          cnt    <= CW'(1);
          o_busy <= 1'b1;
          if (i_mode) begin
            o_cmd <= C_REL_RAM;
            state <= S_PRE;
          end else if (i_num_words == '0) begin
            state <= S_DONE;
          end else begin
            o_cmd <= rd_cmd(1'b0, '0, i_base_adrs);
            state <= S_WAIT;
          end
        end
        S_PRE: begin
          o_cmd <= C_ARM;
          cnt   <= CW'(1);
          state <= S_ARM;
        end
        S_ARM: if (held) begin
          o_cmd <= C_FRZ;
          cnt   <= CW'(1);
          state <= S_FRZ;
        end else cnt <= cnt + 1'b1;
        S_FRZ: if (held) begin
          o_cmd <= rd_cmd(1'b1, '0, base);
          cnt   <= CW'(1);
          state <= S_WAIT;
        end else cnt <= cnt + 1'b1;
        S_WAIT: if (held) begin
          o_data  <= i_rdata;
          o_index <= idx[NB_ADDR-1:0];
          o_valid <= 1'b1;
          state   <= S_PRES;
        end else cnt <= cnt + 1'b1;
        S_PRES: if (i_ready) begin
          o_valid <= 1'b0;
          if (last) begin
            o_cmd <= mode ? C_REL_BER : C_REL_RAM;
            state <= S_REL;
          end else begin
            idx   <= nxt;
            o_cmd <= rd_cmd(mode, nxt, base);
            cnt   <= CW'(1);
            state <= S_WAIT;
          end
        end
        S_REL: begin
          o_cmd <= '0;
          state <= S_DONE;
        end
        default: begin
          o_cmd  <= '0;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_rd_master.sv
// tb_gpio_rd_master: random and directed sequences checked against a transaction-level command/word model
module tb_gpio_rd_master;
  localparam int W = 4;
  logic        clockdsp = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_mode = 1'b0, i_ready = 1'b1;
  logic [15:0] i_base_adrs = '0;
  logic [16:0] i_num_words = '0;
  logic [31:0] o_cmd, i_rdata, o_data;
  logic        o_valid, o_busy, o_done;
  logic [15:0] o_index;
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] ber [8];
  logic [15:0] salt = '0;
  int rdy_mode = 0, stall_n = 0;

  gpio_rd_master #(.WAIT_CYC(W), .NB_ADDR(16)) dut (
    .clockdsp(clockdsp), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
    .i_base_adrs(i_base_adrs), .i_num_words(i_num_words), .o_cmd(o_cmd), .i_rdata(i_rdata),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_index(o_index),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clockdsp = ~clockdsp;
  always @(posedge clockdsp) cyc <= cyc + 1;

  // register-file model: RAM read returns address+0xA000, BER read returns the frozen counter word
  assign i_rdata = (o_cmd[31:24] == 8'h04 && o_cmd[16]) ? {salt, o_cmd[15:0] + 16'hA000} :
                   (o_cmd[31:24] == 8'h06 && o_cmd[3]) ? ber[o_cmd[2:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clockdsp) begin
    #1;
    if (rdy_mode == 0) i_ready = 1'b1;
    else if (rdy_mode == 1) i_ready = 1'($urandom % 2);
    else if (o_valid && o_index == 16'd1 && stall_n < 10) begin
      i_ready = 1'b0;
      stall_n++;
    end else i_ready = 1'b1;
  end

  logic [31:0] cmd_q [$];
  int          cmd_t [$];
  logic [15:0] xi_q [$];
  logic [31:0] xd_q [$];
  int          done_n = 0, t_valid = -1, t_done = -1;
  logic [31:0] pcmd = '0, pdata = '0;
  logic [15:0] pidx = '0;
  logic        pstall = 1'b0, prst = 1'b1;

  always @(negedge clockdsp) begin
    if (o_cmd !== pcmd) begin
      cmd_q.push_back(o_cmd);
      cmd_t.push_back(cyc);
    end
    if (pstall && !prst && !i_reset) begin
      chk("stall_data", o_data, pdata);
      chk("stall_index", o_index, pidx);
      chk("stall_cmd", o_cmd, pcmd);
    end
    if (o_valid && t_valid < 0) t_valid = cyc;
    if (o_valid && i_ready) begin
      xi_q.push_back(o_index);
      xd_q.push_back(o_data);
    end
    if (o_done) begin
      done_n++;
      t_done = cyc;
    end
    pcmd = o_cmd; pdata = o_data; pidx = o_index;
    pstall = o_valid && !i_ready; prst = i_reset;
  end

  task automatic set_ber(input logic [63:0] ei, input logic [63:0] bi,
                         input logic [63:0] eq, input logic [63:0] bq);
    logic [63:0] c [4];
    c[0] = ei; c[1] = bi; c[2] = eq; c[3] = bq;
    for (int k = 0; k < 4; k++) begin
      ber[2*k]   = c[k][31:0];
      ber[2*k+1] = c[k][63:32];
    end
  endtask

  task automatic run_seq(input logic m, input logic [15:0] b, input logic [16:0] n, input int rm);
    logic [31:0] ec [$];
    logic [31:0] ed [$];
    int t0, nc;
    cmd_q.delete(); cmd_t.delete(); xi_q.delete(); xd_q.delete();
    done_n = 0; t_valid = -1; t_done = -1; stall_n = 0; rdy_mode = rm;
    if (m) begin
      ec = '{32'h0480_0000, 32'h0580_0001, 32'h0580_0000};
      for (int i = 0; i < 8; i++) begin
        ec.push_back(32'h0680_0008 + i);
        ed.push_back(ber[i]);
      end
      ec.push_back(32'h0680_0000);
      ec.push_back(32'h0);
    end else if (n != 0) begin
      for (int i = 0; i < int'(n); i++) begin
        ec.push_back(32'h0481_0000 + ((int'(b) + i) % 65536));
        ed.push_back({salt, 16'((int'(b) + i) % 65536 + 32'hA000)});
      end
      ec.push_back(32'h0480_0000);
      ec.push_back(32'h0);
    end
    @(posedge clockdsp); #1;
    i_start = 1'b1; i_mode = m; i_base_adrs = b; i_num_words = n; t0 = cyc;
    @(posedge clockdsp); #1;
    i_start = 1'b0; i_mode = 1'($urandom); i_base_adrs = 16'($urandom); i_num_words = 17'($urandom);
    chk("busy_after_start", o_busy, 1);
    for (int k = 0; k < 5000 && done_n == 0; k++) @(negedge clockdsp);
    repeat (3) @(negedge clockdsp);
    chk("done_count", done_n, 1);
    chk("busy_end", o_busy, 0);
    chk("cmd_count", cmd_q.size(), ec.size());
    chk("word_count", xd_q.size(), ed.size());
    for (int i = 0; i < ec.size() && i < cmd_q.size(); i++) chk("cmd", cmd_q[i], ec[i]);
    for (int i = 0; i < ed.size() && i < xd_q.size(); i++) begin
      chk("index", xi_q[i], i);
      chk("data", xd_q[i], ed[i]);
    end
    nc = cmd_t.size();
    if (ec.size() == 0) chk("done_time_zero_len", t_done, t0 + 2);
    else if (nc == ec.size()) begin
      chk("release_len", cmd_t[nc-1] - cmd_t[nc-2], 1);
      chk("done_after_release", t_done - cmd_t[nc-1], 1);
      if (m) begin
        chk("arm_hold", cmd_t[2] - cmd_t[1], W);
        chk("freeze_hold", cmd_t[3] - cmd_t[2], W);
        chk("first_ber_read_time", cmd_t[3], t0 + 2 + 2*W);
      end else begin
        chk("first_cmd_time", cmd_t[0], t0 + 1);
        chk("first_valid_time", t_valid, t0 + 1 + W);
      end
    end
    if (rm == 2) chk("stall_cycles", stall_n, 10);
  endtask

  task automatic reset_mid(input logic [15:0] b);
    cmd_q.delete(); cmd_t.delete(); xi_q.delete(); xd_q.delete(); rdy_mode = 0;
    @(posedge clockdsp); #1;
    i_start = 1'b1; i_mode = 1'b0; i_base_adrs = b; i_num_words = 17'd6;
    @(posedge clockdsp); #1;
    i_start = 1'b0;
    for (int k = 0; k < 200 && o_cmd !== (32'h0481_0000 | 32'(16'(b + 16'd2)));
         k++) @(posedge clockdsp);
    @(posedge clockdsp); #1;
    chk("mid_reset_word2", o_cmd, 32'h0481_0000 | 32'(16'(b + 16'd2)));
    i_reset = 1'b1; i_start = 1'b1;
    @(posedge clockdsp); #1;
    chk("mid_reset_cmd", o_cmd, 0);
    chk("mid_reset_valid", o_valid, 0);
    chk("mid_reset_busy", o_busy, 0);
    chk("mid_reset_done", o_done, 0);
    chk("mid_reset_index", o_index, 0);
    chk("mid_reset_data", o_data, 0);
    i_reset = 1'b0; i_start = 1'b0;
    repeat (2) @(posedge clockdsp);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b1;
    set_ber(64'h1_0000_0002, 64'h3_1234_5678, 64'h0_0000_00AB, 64'h5_0000_0007);
    repeat (3) @(posedge clockdsp);
    #1;
    chk("reset_cmd", o_cmd, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    i_reset = 1'b0; i_start = 1'b0;
    repeat (3) @(posedge clockdsp);
    #1;
    chk("start_in_reset_ignored", o_busy, 0);
    chk("idle_cmd", o_cmd, 0);
    run_seq(1'b0, 16'h0010, 17'd3, 0);
    run_seq(1'b0, 16'hFFFF, 17'd2, 0);
    run_seq(1'b0, 16'($urandom), 17'd0, 0);
    run_seq(1'b1, 16'($urandom), 17'($urandom), 0);
    chk("ber_idx0", ber[0], 32'h2);
    chk("ber_idx7", ber[7], 32'h5);
    run_seq(1'b0, 16'($urandom), 17'd4, 2);
    run_seq(1'b1, 16'h0, 17'd0, 2);
    reset_mid(16'($urandom));
    run_seq(1'b0, 16'h0100, 17'd5, 0);
    for (int r = 0; r < 12; r++) begin
      salt = 16'($urandom);
      set_ber({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      run_seq(1'($urandom), 16'($urandom), 17'($urandom_range(0, 12)), $urandom_range(0, 1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
